load_store_unit: RTL and testbench

- Memory stage of the pipelined core; sits between execute and writeback.
- Takes one decoded memory request (mem_access_type, address, store data, rd) per handshake and drives the data-memory bus.
- Handles byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and bus timeout.
- Returns one response per request to writeback.

---
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage FSM that formats stores, extracts loads, flags misalignment and bus timeout
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_type,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_misaligned,
  output logic            resp_fault,
  output logic            dmem_valid,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_wen,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4,
                         SB = 4'd5, SH = 4'd6, SW = 4'd7;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] type_q, type_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0] rd_q, rd_d;
  logic mis_q, mis_d, fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic req_load, req_store, req_mis, st_q;
  logic [XLEN-1:0] word, ext, fmt_wdata;
  logic [3:0] fmt_wstrb;
  assign req_load  = req_type inside {LB, LH, LW, LBU, LHU};
  assign req_store = req_type inside {SB, SH, SW};
  assign req_mis   = (req_type inside {LH, LHU, SH} && req_addr[0]) ||
                     (req_type inside {LW, SW} && req_addr[1:0] != 2'b00);
  assign st_q      = type_q inside {SB, SH, SW};
  assign word = dmem_rdata >> {addr_q[1:0], 3'b000};
  assign ext  = type_q == LB  ? {{24{word[7]}}, word[7:0]} :
                type_q == LBU ? {24'b0, word[7:0]} :
                type_q == LH  ? {{16{word[15]}}, word[15:0]} :
                type_q == LHU ? {16'b0, word[15:0]} : word;
  assign fmt_wstrb = type_q == SB ? 4'b0001 << addr_q[1:0] :
                     type_q == SH ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                     type_q == SW ? 4'b1111 : 4'b0000;
  assign fmt_wdata = type_q == SB ? {4{wdata_q[7:0]}} :
                     type_q == SH ? {2{wdata_q[15:0]}} :
                     type_q == SW ? wdata_q : '0;
  assign req_ready       = state_q == IDLE;
  assign dmem_valid      = state_q == REQ;
  assign resp_valid      = state_q == RESP;
  assign dmem_addr       = dmem_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_wen        = dmem_valid && st_q;
  assign dmem_wstrb      = dmem_valid ? fmt_wstrb : 4'b0000;
  assign dmem_wdata      = dmem_valid ? fmt_wdata : '0;
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_rd         = resp_valid ? rd_q : 5'd0;
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_fault      = resp_valid && fault_q;
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        type_d  = req_type;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rd_d    = req_rd;
        rdata_d = '0;
        mis_d   = req_mis;
        fault_d = 1'b0;
        state_d = (req_mis || !(req_load || req_store)) ? RESP : REQ;
      end
      REQ: if (dmem_ready) begin
        cnt_d   = '0;
        state_d = st_q ? RESP : WAIT;
      end
      WAIT: if (dmem_rvalid) begin
        rdata_d = ext;
        state_d = RESP;
      end else if (BUS_TIMEOUT != 0 && cnt_q == 32'(BUS_TIMEOUT - 1)) begin
        fault_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 32'd1;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit
module tb_load_store_unit;
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4,
                         SB = 4'd5, SH = 4'd6, SW = 4'd7, MEM_NONE = 4'd8;
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, resp_valid, resp_ready, resp_misaligned, resp_fault;
  logic [3:0] req_type, dmem_wstrb;
  logic [31:0] req_addr, req_wdata, resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0] req_rd, resp_rd;
  logic dmem_valid, dmem_ready, dmem_wen, dmem_rvalid;
  int checks = 0, errors = 0;
  load_store_unit #(.XLEN(32), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_wen(dmem_wen), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    chk("issue_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    step();
    req_valid = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [3:0] t, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] word, input int delay, input logic [31:0] exp);
    issue(t, a, 32'h0, rd);
    chk({tag, "_dvalid"}, 32'(dmem_valid), 32'd1);
    chk({tag, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
    step();
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_wait"}, 32'(resp_valid), 32'd0);
      step();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    step();
    dmem_rvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    step();
  endtask
  task automatic do_quick(input string tag, input logic [3:0] t, input logic [31:0] a, input logic mis);
    issue(t, a, 32'hFFFF_FFFF, 5'd3);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_mis"}, 32'(resp_misaligned), 32'(mis));
    chk({tag, "_fault"}, 32'(resp_fault), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_dvalid"}, 32'(dmem_valid), 32'd0);
    step();
    chk({tag, "_dvalid2"}, 32'(dmem_valid), 32'd0);
  endtask
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_type = 4'd0; req_addr = '0; req_wdata = '0; req_rd = '0;
    resp_ready = 1'b1; dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    issue(SB, 32'h1003, 32'h0000_00A5, 5'd1);
    chk("sb_dvalid", 32'(dmem_valid), 32'd1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_wstrb", 32'(dmem_wstrb), 32'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_wen", 32'(dmem_wen), 32'd1);
    step();
    chk("sb_rvalid", 32'(resp_valid), 32'd1);
    chk("sb_rdata", resp_rdata, 32'd0);
    step();
    chk("sb_idle", 32'(req_ready), 32'd1);
    do_load("lb", LB, 32'h2001, 5'd5, 32'h1234_80FF, 2, 32'hFFFF_FF80);
    do_load("lbu", LBU, 32'h2001, 5'd6, 32'h1234_80FF, 2, 32'h0000_0080);
    do_load("lhu", LHU, 32'h2002, 5'd7, 32'h1234_80FF, 2, 32'h0000_1234);
    do_load("lh", LH, 32'h2000, 5'd8, 32'h1234_80FF, 0, 32'hFFFF_80FF);
    do_load("lw", LW, 32'h2004, 5'd9, 32'h89AB_CDEF, 1, 32'h89AB_CDEF);
    do_quick("mis_lw", LW, 32'h3002, 1'b1);
    do_quick("mis_sh", SH, 32'h3001, 1'b1);
    do_quick("none", MEM_NONE, 32'h3003, 1'b0);
    dmem_ready = 1'b0;
    resp_ready = 1'b0;
    issue(SH, 32'h1002, 32'h1234_BEEF, 5'd10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_dvalid", 32'(dmem_valid), 32'd1);
      chk("stall_addr", dmem_addr, 32'h1000);
      chk("stall_wdata", dmem_wdata, 32'hBEEF_BEEF);
      chk("stall_wstrb", 32'(dmem_wstrb), 32'b1100);
      if (i == 4) dmem_ready = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_rvalid", 32'(resp_valid), 32'd1);
      chk("hold_rd", 32'(resp_rd), 32'd10);
      chk("hold_rdata", resp_rdata, 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("hold_idle", 32'(req_ready), 32'd1);
    issue(LW, 32'h5000, 32'h0, 5'd11);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", 32'(resp_valid), 32'd0);
      step();
    end
    chk("to_rvalid", 32'(resp_valid), 32'd1);
    chk("to_fault", 32'(resp_fault), 32'd1);
    chk("to_mis", 32'(resp_misaligned), 32'd0);
    chk("to_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    chk("late_rdata", resp_rdata, 32'd0);
    chk("late_fault", 32'(resp_fault), 32'd1);
    resp_ready = 1'b1;
    step();
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("idle_rvalid_ignored", 32'(resp_valid), 32'd0);
    issue(LW, 32'h6000, 32'h0, 5'd12);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst_dvalid", 32'(dmem_valid), 32'd0);
    chk("mrst_addr", dmem_addr, 32'd0);
    chk("mrst_rd", 32'(resp_rd), 32'd0);
    do_load("post_rst", LW, 32'h4000, 5'd17, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
